// File: rtl/spi_write_controller_if.sv
// rtl/spi_write_controller_if.sv - request handshake and SPI bus signals of spi_write_controller
interface spi_write_controller_if;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       busy;
  logic       done;
  logic       err;
  logic       sclk;
  logic       copi;
  logic       ncs;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, busy, done, err, sclk, copi, ncs
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, busy, done, err, sclk, copi, ncs
  );
endinterface

// File: rtl/spi_write_controller.sv
// rtl/spi_write_controller.sv - mode-0 SPI write initiator, 16-bit {1, addr, data} frames MSB first
// Optional SPI_CTRL_ADDR_CHECK_EN: addresses above 7'h04 are accepted silently and flagged on err.
module spi_write_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_write_controller_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT_HI, SHIFT_LO, GAP} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [3:0]  bit_cnt;
  logic [15:0] frame;
  logic        phase_end;
  logic        accept;

  assign phase_end = (cnt == 8'(CLK_DIV - 1));
  assign accept    = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      frame         <= '0;
      bus.req_ready <= 1'b1;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.sclk      <= 1'b0;
      bus.copi      <= 1'b0;
      bus.ncs       <= 1'b1;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      if (state != IDLE) cnt <= phase_end ? 8'd0 : cnt + 8'd1;

      case (state)
        IDLE: begin
          if (accept) begin
`ifdef SPI_CTRL_ADDR_CHECK_EN
            if (bus.req_addr > 7'h04) bus.err <= 1'b1;
            else
`endif
            begin
              frame         <= {1'b1, bus.req_addr, bus.req_data};
              bit_cnt       <= 4'd15;
              state         <= LEAD;
              bus.ncs       <= 1'b0;
              bus.copi      <= 1'b1;
              bus.req_ready <= 1'b0;
              bus.busy      <= 1'b1;
            end
          end
        end
        LEAD: begin
          if (phase_end) begin
            state    <= SHIFT_HI;
            bus.sclk <= 1'b1;
          end
        end
        SHIFT_HI: begin
          if (phase_end) begin
            state    <= SHIFT_LO;
            bus.sclk <= 1'b0;
            // next bit changes with the falling edge; bit 0 is held through the trailing phase
            if (bit_cnt != 4'd0) bus.copi <= frame[bit_cnt - 4'd1];
          end
        end
        SHIFT_LO: begin
          if (phase_end) begin
            if (bit_cnt != 4'd0) begin
              bit_cnt  <= bit_cnt - 4'd1;
              state    <= SHIFT_HI;
              bus.sclk <= 1'b1;
            end else begin
              state    <= GAP;
              bus.ncs  <= 1'b1;
              bus.copi <= 1'b0;
            end
          end
        end
        GAP: begin
          if (phase_end) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
